// File: rtl/oven_clock_ctrl.sv
// oven_clock_ctrl: oven front-panel time-of-day controller (BCD HH:MM, RUN/SET_HR/SET_MIN)
//   clk, rst_n           clock, asynchronous active-low reset
//   run_en               time advances in RUN only while high
//   btn_mode/inc/dec     debounced buttons, asynchronous to clk
//   minuteCountVal1/2    minutes ones/tens BCD digits
//   hourCountVal1/2      hours ones/tens BCD digits
//   mode                 0=RUN, 1=SET_HR, 2=SET_MIN
//   blink                1 = selected digits visible
//   sec_tick             one-cycle pulse per counted second
module oven_clock_ctrl #(
   parameter int TICK_DIV    = 50000000,
   parameter int SEC_PER_MIN = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [3:0] minuteCountVal1,
   output logic [3:0] minuteCountVal2,
   output logic [3:0] hourCountVal1,
   output logic [3:0] hourCountVal2,
   output logic [1:0] mode,
   output logic       blink,
   output logic       sec_tick
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SEC_PER_MIN - 1);

   typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

   state_t state, state_nx;
   logic [2:0] sync1, sync2, prev, btn_ev;
   logic ev_mode, ev_inc, ev_dec, edit, wrap, half, min_max;
   logic [PW-1:0] presc;
   logic [SW-1:0] sec;
   logic [3:0] m1, m2, h1, h2;
   logic [7:0] min_up, min_dn, hr_up, hr_dn;

   // 2-FF synchronizer followed by a rising-edge detector, bit order {mode, inc, dec}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {btn_mode, btn_inc, btn_dec};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign btn_ev  = sync2 & ~prev;
   assign ev_mode = btn_ev[2];
   assign ev_inc  = btn_ev[1];
   assign ev_dec  = btn_ev[0];
   // a mode event swallows any inc/dec arriving with it; inc+dec together cancel
   assign edit    = !ev_mode && (ev_inc ^ ev_dec);
   assign wrap    = presc == P_LAST;
   assign half    = presc == P_HALF;
   assign sec_tick = (state == RUN) && run_en && wrap;

   assign min_max = (m2 == 4'd5) && (m1 == 4'd9);
   assign min_up  = (m1 == 4'd9) ? {(m2 == 4'd5) ? 4'd0 : m2 + 4'd1, 4'd0} : {m2, m1 + 4'd1};
   assign min_dn  = (m1 == 4'd0) ? {(m2 == 4'd0) ? 4'd5 : m2 - 4'd1, 4'd9} : {m2, m1 - 4'd1};
   assign hr_up   = (h2 == 4'd2 && h1 == 4'd3) ? 8'h00 :
                    (h1 == 4'd9) ? {h2 + 4'd1, 4'd0} : {h2, h1 + 4'd1};
   assign hr_dn   = (h2 == 4'd0 && h1 == 4'd0) ? 8'h23 :
                    (h1 == 4'd0) ? {h2 - 4'd1, 4'd9} : {h2, h1 - 4'd1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ev_mode)
         state_nx = (state == RUN) ? SET_HR : (state == SET_HR) ? SET_MIN : RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         sec   <= '0;
         blink <= 1'b1;
         {m2, m1} <= 8'h00;
         {h2, h1} <= 8'h00;
      end else if (state == RUN) begin
         // blink stays 1 in RUN, which also covers forcing it on entry to SET_HR
         blink <= 1'b1;
         if (run_en) presc <= wrap ? '0 : presc + PW'(1);
         if (sec_tick) begin
            sec <= (sec == S_LAST) ? '0 : sec + SW'(1);
            if (sec == S_LAST) begin
               {m2, m1} <= min_up;
               if (min_max) {h2, h1} <= hr_up;
            end
         end
      end else if (ev_mode && state == SET_MIN) begin
         // leaving set mode restarts the second from scratch
         presc <= '0;
         sec   <= '0;
         blink <= 1'b1;
      end else begin
         presc <= wrap ? '0 : presc + PW'(1);
         if (wrap || half) blink <= ~blink;
         if (edit && state == SET_HR)  {h2, h1} <= ev_inc ? hr_up : hr_dn;
         if (edit && state == SET_MIN) {m2, m1} <= ev_inc ? min_up : min_dn;
      end
   end

   assign minuteCountVal1 = m1;
   assign minuteCountVal2 = m2;
   assign hourCountVal1   = h1;
   assign hourCountVal2   = h2;
   assign mode            = state;
endmodule

// File: tb/tb_oven_clock_ctrl.sv
// tb_oven_clock_ctrl: table-driven, directed and randomized checks of oven_clock_ctrl against a behavioural model
module tb_oven_clock_ctrl;
   localparam int TD  = 4;
   localparam int SPM = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run_en = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
   logic [3:0] minuteCountVal1, minuteCountVal2, hourCountVal1, hourCountVal2;
   logic [1:0] mode;
   logic blink, sec_tick;

   int vectors = 0, miscompares = 0, ticks = 0;

   oven_clock_ctrl #(.TICK_DIV(TD), .SEC_PER_MIN(SPM)) dut (
      .clk(clk), .rst_n(rst_n), .run_en(run_en),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .minuteCountVal1(minuteCountVal1), .minuteCountVal2(minuteCountVal2),
      .hourCountVal1(hourCountVal1), .hourCountVal2(hourCountVal2),
      .mode(mode), .blink(blink), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   // reference model: time as minutes-of-day, buttons as sample histories
   int m_t = 0, m_sec = 0, m_presc = 0, m_mode = 0;
   bit m_blink = 1'b1;
   bit [2:0] hm = '0, hi = '0, hd = '0;

   always @(posedge clk or negedge rst_n) begin
      int t, s, p, md, h, m;
      bit bl, em, ei, ed;
      if (!rst_n) begin
         m_t <= 0; m_sec <= 0; m_presc <= 0; m_mode <= 0; m_blink <= 1'b1;
         hm <= '0; hi <= '0; hd <= '0;
      end else begin
         t = m_t; s = m_sec; p = m_presc; md = m_mode; bl = m_blink;
         em = hm[1] & ~hm[2];
         ei = hi[1] & ~hi[2];
         ed = hd[1] & ~hd[2];
         h = t / 60;
         m = t % 60;
         if (md == 0) begin
            if (run_en) begin
               if (p == TD - 1) begin
                  p = 0;
                  s = s + 1;
                  if (s == SPM) begin
                     s = 0;
                     t = (t + 1) % 1440;
                  end
               end else p = p + 1;
            end
            if (em) begin md = 1; bl = 1'b1; end
         end else if (em && md == 2) begin
            md = 0; s = 0; p = 0; bl = 1'b1;
         end else begin
            if (p == TD / 2 - 1 || p == TD - 1) bl = !bl;
            p = (p + 1) % TD;
            if (em) md = 2;
            else if (ei && !ed) begin
               if (md == 1) h = (h + 1) % 24; else m = (m + 1) % 60;
            end else if (ed && !ei) begin
               if (md == 1) h = (h + 23) % 24; else m = (m + 59) % 60;
            end
            t = h * 60 + m;
         end
         m_t <= t; m_sec <= s; m_presc <= p; m_mode <= md; m_blink <= bl;
         hm <= {hm[1:0], btn_mode};
         hi <= {hi[1:0], btn_inc};
         hd <= {hd[1:0], btn_dec};
      end
   end

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_model();
      check("min1", minuteCountVal1, (m_t % 60) % 10);
      check("min2", minuteCountVal2, (m_t % 60) / 10);
      check("hr1", hourCountVal1, (m_t / 60) % 10);
      check("hr2", hourCountVal2, (m_t / 60) / 10);
      check("mode", mode, m_mode);
      check("blink", blink, m_blink);
      check("sec_tick", sec_tick, (m_mode == 0 && run_en && m_presc == TD - 1) ? 1 : 0);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         chk_model();
         if (sec_tick) ticks++;
      end
   endtask

   task automatic press(input bit bm, input bit bi, input bit bd, input int hold = 1);
      btn_mode = bm; btn_inc = bi; btn_dec = bd;
      cyc(hold);
      btn_mode = 0; btn_inc = 0; btn_dec = 0;
      cyc(3);
   endtask

   function automatic int hrs();
      return hourCountVal2 * 10 + hourCountVal1;
   endfunction

   function automatic int mins();
      return minuteCountVal2 * 10 + minuteCountVal1;
   endfunction

   typedef struct {
      bit bm, bi, bd;
      int hold;
      int e_mode, e_h, e_m;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{1, 1, 0, 1, 1, 0, 1};
      tbl[1]  = '{0, 0, 1, 1, 1, 23, 1};
      tbl[2]  = '{0, 1, 0, 1, 1, 0, 1};
      tbl[3]  = '{0, 0, 1, 2, 1, 23, 1};
      tbl[4]  = '{1, 0, 0, 1, 2, 23, 1};
      tbl[5]  = '{0, 0, 1, 1, 2, 23, 0};
      tbl[6]  = '{0, 0, 1, 1, 2, 23, 59};
      tbl[7]  = '{0, 1, 0, 3, 2, 23, 0};
      tbl[8]  = '{0, 0, 1, 1, 2, 23, 59};
      tbl[9]  = '{0, 1, 1, 1, 2, 23, 59};
      tbl[10] = '{1, 0, 0, 1, 0, 23, 59};

      repeat (3) @(negedge clk);
      check("rst_min", mins(), 0);
      check("rst_hr", hrs(), 0);
      check("rst_mode", mode, 0);
      check("rst_blink", blink, 1);
      check("rst_tick", sec_tick, 0);

      // seconds tick every TD clocks; minute after TD*SPM clocks
      rst_n = 1'b1;
      run_en = 1'b1;
      cyc(2);
      check("t1_no_tick", sec_tick, 0);
      cyc(1);
      check("t1_tick", sec_tick, 1);
      ticks = 0;
      cyc(8);
      check("t1_ticks", ticks, 2);
      check("t1_min_before", mins(), 0);
      cyc(1);
      check("t1_min_after", mins(), 1);
      run_en = 1'b0;

      // editing sequences with time frozen
      foreach (tbl[k]) begin
         press(tbl[k].bm, tbl[k].bi, tbl[k].bd, tbl[k].hold);
         check($sformatf("tbl%0d_mode", k), mode, tbl[k].e_mode);
         check($sformatf("tbl%0d_hr", k), hrs(), tbl[k].e_h);
         check($sformatf("tbl%0d_min", k), mins(), tbl[k].e_m);
      end

      // 23:59 rolls to 00:00 one minute after leaving set mode
      run_en = 1'b1;
      cyc(TD * SPM - 1);
      check("t2_hr_before", hrs(), 23);
      check("t2_min_before", mins(), 59);
      cyc(1);
      check("t2_hr_after", hrs(), 0);
      check("t2_min_after", mins(), 0);
      check("t2_hr2", hourCountVal2, 0);

      // run_en low freezes everything; prescaler resumes from held value
      cyc(1);
      run_en = 1'b0;
      ticks = 0;
      cyc(50);
      check("t5_ticks", ticks, 0);
      check("t5_min", mins(), 0);
      run_en = 1'b1;
      cyc(1);
      check("t5_resume0", sec_tick, 0);
      cyc(1);
      check("t5_resume1", sec_tick, 1);
      run_en = 1'b0;

      // reset in the middle of SET_MIN at 12:34
      press(1, 0, 0);
      repeat (12) press(0, 1, 0);
      press(1, 0, 0);
      repeat (34) press(0, 1, 0);
      check("t6_hr", hrs(), 12);
      check("t6_min", mins(), 34);
      check("t6_mode", mode, 2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_min", mins(), 0);
      check("t6_rst_hr", hrs(), 0);
      check("t6_rst_mode", mode, 0);
      check("t6_rst_blink", blink, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);
      press(1, 1, 0);
      check("t6_modeinc_mode", mode, 1);
      check("t6_modeinc_hr", hrs(), 0);

      // held inc counts once
      press(1, 0, 0);
      repeat (7) press(0, 1, 0);
      check("t4_min7", mins(), 7);
      press(0, 1, 0, 20);
      check("t4_min8", mins(), 8);
      press(1, 0, 0);
      check("t4_mode", mode, 0);

      // randomized stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         run_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
         if ($urandom_range(0, 3) == 0) btn_dec = ~btn_dec;
         cyc(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
